// File: rtl/tri_scheduler.sv
// tri_scheduler: FIFO-buffered triangle sequencer that hands one triangle at a time to the rasterizer.
// Define TRI_SCHED_STATS_EN to enable the completed-triangle counter on o_tri_count.
module tri_scheduler #(
    parameter  int unsigned DEPTH   = 8,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned COORD_W = 16,
    localparam int unsigned TRI_W   = 9 * COORD_W,
    localparam int unsigned COLOR_W = 24
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [TRI_W-1:0]   i_triangle,
    input  logic [COLOR_W-1:0] i_color,
    input  logic               i_last,
    input  logic               i_pause,
    output logic [TRI_W-1:0]   rast_triangle,
    output logic [COLOR_W-1:0] rast_color,
    output logic               rast_start,
    input  logic               rast_done,
    output logic               frame_done,
    output logic               busy,
    output logic [CNT_W-1:0]   o_tri_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle3d_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color_t;

    typedef struct packed {
        triangle3d_t tri_v;
        color_t      color;
        logic        last;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FDONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    entry_t             mem_q [DEPTH];
    entry_t             wr_entry;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]   count_q, count_d;
    logic               ready_q, busy_q, start_q, fdone_q, last_q;
    logic [TRI_W-1:0]   rast_tri_q;
    logic [COLOR_W-1:0] rast_col_q;
    logic               push, pop, empty;

    assign empty = (count_q == '0);
    assign push  = i_valid && ready_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_entry       = '0;
        wr_entry.tri_v = triangle3d_t'(i_triangle);
        wr_entry.color = color_t'(i_color);
        wr_entry.last  = i_last;
    end

    // Next-state and pop decision; only IDLE may pull a new triangle.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && !i_pause) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (rast_done) begin
                    state_d = last_q ? S_FDONE : S_IDLE;
                end
            end
            S_FDONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Control and output registers; flags are computed from next-state so they line up with the state.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            fdone_q    <= 1'b0;
            last_q     <= 1'b0;
            rast_tri_q <= '0;
            rast_col_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= (count_d != OCC_W'(DEPTH));
            busy_q  <= (state_d != S_IDLE) || (count_d != '0);
            start_q <= (state_d == S_ISSUE);
            fdone_q <= (state_d == S_FDONE);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                rast_tri_q <= TRI_W'(head.tri_v);
                rast_col_q <= COLOR_W'(head.color);
                last_q     <= head.last;
            end
        end
    end

    assign i_ready       = ready_q;
    assign busy          = busy_q;
    assign rast_start    = start_q;
    assign frame_done    = fdone_q;
    assign rast_triangle = rast_tri_q;
    assign rast_color    = rast_col_q;

`ifdef TRI_SCHED_STATS_EN
    logic [CNT_W-1:0] tri_cnt_q, tri_cnt_d;

    // Frame total stays visible through FDONE, then clears.
    always_comb begin
        tri_cnt_d = tri_cnt_q;
        if (state_q == S_FDONE) begin
            tri_cnt_d = '0;
        end else if ((state_q == S_WAIT) && rast_done && (tri_cnt_q != '1)) begin
            tri_cnt_d = tri_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            tri_cnt_q <= '0;
        end else begin
            tri_cnt_q <= tri_cnt_d;
        end
    end

    assign o_tri_count = tri_cnt_q;
`else
    assign o_tri_count = '0;
`endif

endmodule

// File: tb/tb_tri_scheduler.sv
// Self-checking bench for tri_scheduler: cycle table for single-triangle/pause flows plus
// hand sequences for fill, push+pop, level-held done, stats and mid-operation reset.
module tb_tri_scheduler;

    localparam int unsigned TRI_W   = 144;
    localparam int unsigned COLOR_W = 24;
    localparam int unsigned CNT_W   = 16;

    logic               clk = 1'b0;
    logic               n_rst = 1'b0;
    logic               i_valid = 1'b0;
    logic               i_ready;
    logic [TRI_W-1:0]   i_triangle = '0;
    logic [COLOR_W-1:0] i_color = '0;
    logic               i_last = 1'b0;
    logic               i_pause = 1'b0;
    logic [TRI_W-1:0]   rast_triangle;
    logic [COLOR_W-1:0] rast_color;
    logic               rast_start;
    logic               rast_done;
    logic               frame_done;
    logic               busy;
    logic [CNT_W-1:0]   o_tri_count;

    tri_scheduler dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .i_valid       (i_valid),
        .i_ready       (i_ready),
        .i_triangle    (i_triangle),
        .i_color       (i_color),
        .i_last        (i_last),
        .i_pause       (i_pause),
        .rast_triangle (rast_triangle),
        .rast_color    (rast_color),
        .rast_start    (rast_start),
        .rast_done     (rast_done),
        .frame_done    (frame_done),
        .busy          (busy),
        .o_tri_count   (o_tri_count)
    );

    always #5 clk = ~clk;

    // Rasterizer model: done rises lat cycles after start, stays up for hold cycles, drops on start.
    int   lat = 4;
    int   hold = 1;
    int   cd = 0;
    logic auto_en = 1'b0;
    logic man_done = 1'b0;
    logic auto_done;

    always @(posedge clk) begin
        if (!n_rst)          cd <= 0;
        else if (rast_start) cd <= lat + hold - 1;
        else if (cd != 0)    cd <= cd - 1;
    end
    assign auto_done = (cd != 0) && (cd <= hold);
    assign rast_done = auto_en ? auto_done : man_done;

    int   n_chk = 0;
    int   n_fail = 0;
    int   n_starts = 0;
    int   n_fd = 0;
    int   exp_frame = 0;
    logic mon_en = 1'b0;
    logic clr_pending = 1'b0;
    logic [TRI_W+COLOR_W-1:0] q [$];

    function automatic logic [TRI_W-1:0] mk_tri(int k);
        logic [TRI_W-1:0] t;
        for (int j = 0; j < 9; j++) t[j*16 +: 16] = 16'(k * 100 + j * k);
        return t;
    endfunction

    function automatic logic [COLOR_W-1:0] mk_col(int k);
        return 24'(k * 24'h010203);
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [TRI_W+COLOR_W-1:0] act,
                        input logic [TRI_W+COLOR_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and run the start/frame monitors.
    task automatic step();
        logic [CNT_W-1:0] exp_cnt;
        @(negedge clk);
        if (clr_pending) begin
            clr_pending = 1'b0;
            chki("tri_count_clear", int'(o_tri_count), 0);
        end
        if (frame_done) begin
            n_fd++;
`ifdef TRI_SCHED_STATS_EN
            exp_cnt = 16'(exp_frame);
`else
            exp_cnt = '0;
`endif
            chki("tri_count_at_fdone", int'(o_tri_count), int'(exp_cnt));
            clr_pending = 1'b1;
        end
        if (mon_en && rast_start) begin
            n_starts++;
            if (q.size() == 0) begin
                chki("unexpected_start", 1, 0);
            end else begin
                chkv("start_order", {rast_triangle, rast_color}, q.pop_front());
            end
        end
    endtask

    task automatic drive(input logic v, input int k, input logic last);
        i_valid    = v;
        i_triangle = v ? mk_tri(k) : '0;
        i_color    = v ? mk_col(k) : '0;
        i_last     = last;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while ((q.size() != 0 || busy) && g < 400) begin
            step();
            g++;
        end
        chk1({name, "_drained"}, (g < 400), 1'b1);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk1({pfx, "_ready"}, i_ready, 1'b1);
        chk1({pfx, "_start"}, rast_start, 1'b0);
        chk1({pfx, "_fdone"}, frame_done, 1'b0);
        chk1({pfx, "_busy"}, busy, 1'b0);
        chkv({pfx, "_rast_data"}, {rast_triangle, rast_color}, '0);
        chki({pfx, "_tri_count"}, int'(o_tri_count), 0);
    endtask

    typedef struct {
        logic v, l, p, d;
        int   t;
        logic rdy, st, fd, bsy;
        int   e;
    } vec_t;

    function automatic vec_t mkv(logic v, logic l, logic p, logic d, int t,
                                 logic rdy, logic st, logic fd, logic bsy, int e);
        vec_t r;
        r.v = v; r.l = l; r.p = p; r.d = d; r.t = t;
        r.rdy = rdy; r.st = st; r.fd = fd; r.bsy = bsy; r.e = e;
        return r;
    endfunction

    vec_t tbl [24];

    initial begin
        int acc, s0, f0;

        // Row r: outputs expected during cycle r, inputs applied during cycle r.
        tbl[0] = mkv(1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        tbl[1] = mkv(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[2] = mkv(0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
        for (int r = 3; r <= 11; r++) tbl[r] = mkv(0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        tbl[12] = mkv(0, 0, 0, 1, 0, 1, 0, 0, 1, 1);
        tbl[13] = mkv(0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
        tbl[14] = mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        tbl[15] = mkv(1, 1, 1, 0, 2, 1, 0, 0, 0, 1);
        tbl[16] = mkv(0, 0, 1, 0, 0, 1, 0, 0, 1, 1);
        tbl[17] = mkv(0, 0, 1, 0, 0, 1, 0, 0, 1, 1);
        tbl[18] = mkv(0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        tbl[19] = mkv(0, 0, 0, 0, 0, 1, 1, 0, 1, 2);
        tbl[20] = mkv(0, 0, 0, 1, 0, 1, 0, 0, 1, 2);
        tbl[21] = mkv(0, 0, 0, 1, 0, 1, 0, 1, 1, 2);
        tbl[22] = mkv(0, 0, 0, 1, 0, 1, 0, 0, 0, 2);
        tbl[23] = mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 2);

        repeat (3) step();
        chk_reset_vals("reset");
        n_rst = 1'b1;

        exp_frame = 1;
        for (int r = 0; r < 24; r++) begin
            step();
            chk1($sformatf("tbl%0d_ready", r), i_ready, tbl[r].rdy);
            chk1($sformatf("tbl%0d_start", r), rast_start, tbl[r].st);
            chk1($sformatf("tbl%0d_fdone", r), frame_done, tbl[r].fd);
            chk1($sformatf("tbl%0d_busy", r), busy, tbl[r].bsy);
            chkv($sformatf("tbl%0d_rast_data", r), {rast_triangle, rast_color},
                 {mk_tri(tbl[r].e), mk_col(tbl[r].e)});
            drive(tbl[r].v, tbl[r].t, tbl[r].l);
            i_pause  = tbl[r].p;
            man_done = tbl[r].d;
        end

        // Fill while paused: nine offered, eight accepted, then drain in order.
        mon_en = 1'b1; auto_en = 1'b1; lat = 4; hold = 1; exp_frame = 8;
        i_pause = 1'b1; acc = 0; s0 = n_starts; f0 = n_fd;
        for (int i = 0; i < 9; i++) begin
            step();
            drive(1'b1, 10 + i, (i == 7));
            if (i_ready) begin
                q.push_back({mk_tri(10 + i), mk_col(10 + i)});
                acc++;
            end
        end
        step();
        drive(1'b0, 0, 1'b0);
        chki("fill_accepted", acc, 8);
        chk1("fill_ready_low", i_ready, 1'b0);
        chk1("fill_busy", busy, 1'b1);
        i_pause = 1'b0;
        step();
        chk1("ready_after_first_pop", i_ready, 1'b1);
        drain("fill");
        chki("fill_starts", n_starts - s0, 8);
        chki("fill_frames", n_fd - f0, 1);

        // Push and pop in the same cycle at DEPTH-1, with level-held done.
        lat = 3; hold = 3; exp_frame = 8;
        i_pause = 1'b1; s0 = n_starts; f0 = n_fd;
        for (int i = 0; i < 7; i++) begin
            step();
            drive(1'b1, 30 + i, 1'b0);
            q.push_back({mk_tri(30 + i), mk_col(30 + i)});
        end
        step();
        chk1("ready_at_seven", i_ready, 1'b1);
        i_pause = 1'b0;
        drive(1'b1, 37, 1'b1);
        q.push_back({mk_tri(37), mk_col(37)});
        step();
        drive(1'b0, 0, 1'b0);
        chk1("pushpop_ready_held", i_ready, 1'b1);
        drain("pushpop");
        chki("pushpop_starts", n_starts - s0, 8);
        chki("pushpop_frames", n_fd - f0, 1);

        // Five-triangle frame for the statistics counter.
        lat = 2; hold = 1; exp_frame = 5; s0 = n_starts; f0 = n_fd;
        for (int i = 0; i < 5; i++) begin
            step();
            drive(1'b1, 50 + i, (i == 4));
            q.push_back({mk_tri(50 + i), mk_col(50 + i)});
        end
        step();
        drive(1'b0, 0, 1'b0);
        drain("stats");
        chki("stats_starts", n_starts - s0, 5);
        chki("stats_frames", n_fd - f0, 1);

        // Reset while waiting on the rasterizer with four entries queued.
        auto_en = 1'b0; man_done = 1'b0; s0 = n_starts;
        for (int i = 0; i < 5; i++) begin
            step();
            drive(1'b1, 70 + i, 1'b0);
            q.push_back({mk_tri(70 + i), mk_col(70 + i)});
        end
        step();
        drive(1'b0, 0, 1'b0);
        repeat (3) step();
        chki("pre_reset_starts", n_starts - s0, 1);
        chk1("pre_reset_busy", busy, 1'b1);
        q.delete();
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        chk_reset_vals("midreset");
        s0 = n_starts;
        repeat (10) step();
        chki("no_start_after_reset", n_starts - s0, 0);
        chk1("idle_after_reset", busy, 1'b0);
        auto_en = 1'b1; lat = 3; hold = 1; exp_frame = 1; f0 = n_fd;
        drive(1'b1, 80, 1'b1);
        q.push_back({mk_tri(80), mk_col(80)});
        step();
        drive(1'b0, 0, 1'b0);
        drain("post_reset");
        chki("post_reset_starts", n_starts - s0, 1);
        chki("post_reset_frames", n_fd - f0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
